// File: rtl/sync_fifo_ctrl_if.sv
// Request/status bundle between a producer/consumer pair and the FIFO
// controller. The controller takes the slave view; whoever drives the
// requests and watches the flags takes the master view.
interface sync_fifo_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic              wr_req;
  logic              rd_req;
  logic              clr_err;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_raddr;
  logic              rd_valid;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_req, rd_req, clr_err,
    input  ram_we, ram_waddr, ram_re, ram_raddr, rd_valid, count,
           full, empty, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  wr_req, rd_req, clr_err,
    output ram_we, ram_waddr, ram_re, ram_raddr, rd_valid, count,
           full, empty, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller for an external synchronous-read RAM.
// Owns the write/read pointers, the occupancy count, the level flags and
// the sticky overflow/underflow errors. Acceptance is decided from the
// registered flags, so RAM enables are a single gate away from the requests.
module sync_fifo_ctrl #(
  parameter int ADDR_W    = 4,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2
) (
  input logic             clk,
  input logic             reset_n,
  sync_fifo_ctrl_if.slave bus
);
  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_V  = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AFULL_V  = AFULL_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] AEMPTY_V = AEMPTY_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0] wptr_q, wptr_d;
  logic [ADDR_W:0] rptr_q, rptr_d;
  logic [ADDR_W:0] count_q, count_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            afull_q, afull_d;
  logic            aempty_q, aempty_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;
  logic            rd_valid_q, rd_valid_d;
  logic            wr_acc;
  logic            rd_acc;

  // At full with both requests only the read goes; at empty only the write.
  assign wr_acc = bus.wr_req & ~full_q;
  assign rd_acc = bus.rd_req & ~empty_q;

  // Next-state: pointers, count, flags from the next count, sticky errors.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    rd_valid_d = rd_acc;

    if (wr_acc) wptr_d = wptr_q + ONE;
    if (rd_acc) rptr_d = rptr_q + ONE;

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase

    full_d   = (count_d == DEPTH_V);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AFULL_V);
    aempty_d = (count_d <= AEMPTY_V);

    // A set in the same cycle as clr_err wins.
    ovf_d = (bus.wr_req & full_q)  | (ovf_q & ~bus.clr_err);
    udf_d = (bus.rd_req & empty_q) | (udf_q & ~bus.clr_err);
  end

  // State registers; synchronous reset discards all contents.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.ram_we       = wr_acc;
  assign bus.ram_waddr    = wptr_q[ADDR_W-1:0];
  assign bus.ram_re       = rd_acc;
  assign bus.ram_raddr    = rptr_q[ADDR_W-1:0];
  assign bus.rd_valid     = rd_valid_q;
  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

  // Occupancy must always equal the pointer distance.
  count_matches_ptrs : assert property (
    @(posedge clk) disable iff (!reset_n) count_q == (wptr_q - rptr_q)
  );
endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Single-clock FIFO controller that owns the write and read pointers for an external synchronous-read RAM and generates all occupancy flags. It sits between producer/consumer request lines and the storage array, sequences every RAM access, and guards the array against overflow and underflow. Its status outputs feed the upstream throttle logic and a sticky error register.

## Interface
- ADDR_W, 4: RAM address width; DEPTH = 2**ADDR_W entries (16 by default).
- AFULL_TH, 12: almost_full asserts when count >= AFULL_TH.
- AEMPTY_TH, 2: almost_empty asserts when count <= AEMPTY_TH.
- Legal range: 1 <= AEMPTY_TH < AFULL_TH <= DEPTH.

- clk  input  1  clock; all state changes on the rising edge.
- reset_n  input  1  reset, synchronous, active-low.
- wr_req  input  1  producer requests a write this cycle.
- rd_req  input  1  consumer requests a read this cycle.
- clr_err  input  1  clears overflow/underflow sticky flags.
- ram_we  output  1  RAM write enable, combinational: wr_req & ~full.
- ram_waddr  output  ADDR_W  RAM write address = wptr[ADDR_W-1:0].
- ram_re  output  1  RAM read enable, combinational: rd_req & ~empty.
- ram_raddr  output  ADDR_W  RAM read address = rptr[ADDR_W-1:0].
- rd_valid  output  1  registered; RAM read data valid this cycle.
- count  output  ADDR_W+1  registered occupancy, 0..DEPTH.
- full, empty, almost_full, almost_empty  output  1 each  registered flags.
- overflow, underflow  output  1 each  sticky error flags.

## Operation
- Pointers wptr and rptr are ADDR_W+1 bits wide. Low bits address the RAM. The MSB is a wrap bit that toggles each time the low bits roll from DEPTH-1 to 0.
- Write accept: wr_req & ~full. On accept, wptr increments.
- Read accept: rd_req & ~empty. On accept, rptr increments.
- Acceptance always uses the registered flags of the current cycle.
- count next value: +1 on write only, -1 on read only, unchanged on both or neither. count stays within 0..DEPTH; no other arithmetic is performed on it.
- Flags are computed from next count and registered:
  - full = (count == DEPTH)
  - empty = (count == 0)
  - almost_full = (count >= AFULL_TH)
  - almost_empty = (count <= AEMPTY_TH)
- Invariant: count == (wptr - rptr) modulo 2**(ADDR_W+1). A mismatch is a checker error.
- Simultaneous requests:
  - Full, both requesting: read accepted, write rejected. count becomes DEPTH-1.
  - Empty, both requesting: write accepted, read rejected. count becomes 1.
  - Otherwise both are accepted and count is unchanged.
- Errors:
  - overflow sets on wr_req & full.
  - underflow sets on rd_req & empty.
  - Both hold until clr_err. If set and clr_err occur in the same cycle, set wins.
- Rejected requests change no pointer, count, or RAM enable.
- Reset (reset_n low at an edge):
  - wptr = rptr = 0, count = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - overflow = underflow = 0, rd_valid = 0.
  - Reset overrides any request in the same cycle. A reset mid-stream discards all contents; no partial state survives.

## Timing
- Write accepted at edge N: count and flags update at N+1. A read can be accepted at N+1.
- Read accepted at cycle N (ram_re high): rd_valid high in cycle N+1, aligned with RAM output data. rd_valid is low in every other cycle.
- ram_we and ram_re have zero latency from the requests. Their addresses are stable register outputs for the whole cycle.
- Flags lag acceptance by exactly one cycle, with no extra pipeline.
- Back-to-back reads at the full rate produce continuous rd_valid.
- Pointer wrap is seamless: address DEPTH-1 is followed by address 0 with no bubble.

## Test plan
- Reset, then 16 consecutive writes:
  - count steps 1..16.
  - empty falls at cycle 1; almost_empty falls when count = 3; almost_full rises at 12; full rises at 16.
  - ram_waddr runs 0..15.
- Full, then wr_req only: ram_we = 0, count stays 16, overflow = 1. Then clr_err: overflow = 0 next cycle.
- Full, then wr_req and rd_req together: read accepted, write rejected, count = 15, overflow = 1, rd_valid high the next cycle.
- Empty, then rd_req and wr_req together: write accepted, count = 1, underflow = 1, ram_re = 0, no rd_valid.
- Wrap test:
  - Write 10, read 10, then write 10 more: ram_waddr goes 10..15, 0..3 and the wptr MSB toggles.
  - Read 10: ram_raddr follows the same sequence, rd_valid is continuous, final count = 0 and empty = 1.
- Assert reset_n low with count = 7 while wr_req = rd_req = 1: next cycle count = 0, empty = 1, errors = 0, rd_valid = 0. A subsequent write lands at address 0.
